fnd_capture_decoder: RTL

FND_CAPTURE_DECODER -- requirements
Module: fnd_capture_decoder

---
 rtl/fnd_pkg.sv | 27 ++
 rtl/fnd_font_to_bcd.sv | 35 +++
 rtl/fnd_capture_decoder.sv | 118 +++++++++++
 3 files changed

// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - seven-segment font constants and BCD codes shared by encoder and decoder
package fnd_pkg;

    // Active-low segment patterns, bits 6:0 = segments g..a
    localparam logic [6:0] FONT_0     = 7'h40;
    localparam logic [6:0] FONT_1     = 7'h79;
    localparam logic [6:0] FONT_2     = 7'h24;
    localparam logic [6:0] FONT_3     = 7'h30;
    localparam logic [6:0] FONT_4     = 7'h19;
    localparam logic [6:0] FONT_5     = 7'h12;
    localparam logic [6:0] FONT_6     = 7'h02;
    localparam logic [6:0] FONT_7     = 7'h78;
    localparam logic [6:0] FONT_8     = 7'h00;
    localparam logic [6:0] FONT_9     = 7'h10;
    localparam logic [6:0] FONT_BLANK = 7'h7F;

    localparam logic [3:0] BCD_BLANK  = 4'hF;
    localparam logic [3:0] BCD_ERR    = 4'hE;

    // True when exactly one active-low select line is asserted
    function automatic logic one_low(input logic [3:0] com);
        logic [3:0] sel;
        sel = ~com;
        return (sel != 4'h0) && ((sel & (sel - 4'h1)) == 4'h0);
    endfunction

endpackage

// File: rtl/fnd_font_to_bcd.sv
// rtl/fnd_font_to_bcd.sv - combinational segment pattern to BCD lookup
module fnd_font_to_bcd
    import fnd_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_bcd,
    output logic       o_blank,
    output logic       o_err
);

    // Map a legal digit pattern to its value; blank and anything else get marker codes
    always_comb begin
        o_blank = 1'b0;
        o_err   = 1'b0;
        o_bcd   = BCD_ERR;
        case (i_pattern)
            FONT_0:     o_bcd = 4'd0;
            FONT_1:     o_bcd = 4'd1;
            FONT_2:     o_bcd = 4'd2;
            FONT_3:     o_bcd = 4'd3;
            FONT_4:     o_bcd = 4'd4;
            FONT_5:     o_bcd = 4'd5;
            FONT_6:     o_bcd = 4'd6;
            FONT_7:     o_bcd = 4'd7;
            FONT_8:     o_bcd = 4'd8;
            FONT_9:     o_bcd = 4'd9;
            FONT_BLANK: begin
                o_bcd   = BCD_BLANK;
                o_blank = 1'b1;
            end
            default:    o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/fnd_capture_decoder.sv
// rtl/fnd_capture_decoder.sv - captures a scanned 4-digit seven-segment display back into BCD
module fnd_capture_decoder
    import fnd_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [3:0]  i_com,
    input  logic [7:0]  i_font,
    output logic [15:0] o_bcd,
    output logic [3:0]  o_dp,
    output logic [3:0]  o_blank,
    output logic [3:0]  o_err,
    output logic        o_valid
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CNT);
    localparam logic [7:0] CNT_ACC = 8'(STABLE_CNT - 1);

    logic [3:0]  com_meta_q, s_com_q, prev_com_q;
    logic [7:0]  font_meta_q, s_font_q, prev_font_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  seen_q, seen_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  dp_q, dp_d;
    logic [3:0]  blank_q, blank_d;
    logic [3:0]  err_q, err_d;
    logic        valid_q, valid_d;

    logic        same;
    logic        accept;
    logic [3:0]  dec_bcd;
    logic        dec_blank;
    logic        dec_err;

    fnd_font_to_bcd u_font_to_bcd (
        .i_pattern (s_font_q[6:0]),
        .o_bcd     (dec_bcd),
        .o_blank   (dec_blank),
        .o_err     (dec_err)
    );

    // Stability counter; acceptance fires once, on the step from STABLE_CNT-1 to STABLE_CNT
    always_comb begin
        same   = ({s_com_q, s_font_q} == {prev_com_q, prev_font_q});
        cnt_d  = 8'h00;
        if (same) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'h01;
        end
        accept = same && (cnt_q == CNT_ACC) && one_low(s_com_q);
    end

    // Update the selected digit, track which digits were seen, and flag a complete frame
    always_comb begin
        bcd_d   = bcd_q;
        dp_d    = dp_q;
        blank_d = blank_q;
        err_d   = err_q;
        seen_d  = seen_q;
        valid_d = 1'b0;
        if (accept) begin
            for (int n = 0; n < 4; n++) begin
                if (!s_com_q[n]) begin
                    bcd_d[4*n +: 4] = dec_bcd;
                    dp_d[n]         = ~s_font_q[7];
                    blank_d[n]      = dec_blank;
                    err_d[n]        = dec_err;
                    seen_d[n]       = 1'b1;
                end
            end
            if (seen_d == 4'hF) begin
                valid_d = 1'b1;
                seen_d  = 4'h0;
            end
        end
    end

    // Synchronizers, previous-sample register and all captured state
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            com_meta_q  <= 4'hF;
            s_com_q     <= 4'hF;
            prev_com_q  <= 4'hF;
            font_meta_q <= 8'hFF;
            s_font_q    <= 8'hFF;
            prev_font_q <= 8'hFF;
            cnt_q       <= 8'h00;
            seen_q      <= 4'h0;
            bcd_q       <= 16'hFFFF;
            dp_q        <= 4'h0;
            blank_q     <= 4'hF;
            err_q       <= 4'h0;
            valid_q     <= 1'b0;
        end else begin
            com_meta_q  <= i_com;
            s_com_q     <= com_meta_q;
            prev_com_q  <= s_com_q;
            font_meta_q <= i_font;
            s_font_q    <= font_meta_q;
            prev_font_q <= s_font_q;
            cnt_q       <= cnt_d;
            seen_q      <= seen_d;
            bcd_q       <= bcd_d;
            dp_q        <= dp_d;
            blank_q     <= blank_d;
            err_q       <= err_d;
            valid_q     <= valid_d;
        end
    end

    assign o_bcd   = bcd_q;
    assign o_dp    = dp_q;
    assign o_blank = blank_q;
    assign o_err   = err_q;
    assign o_valid = valid_q;

endmodule
